// File: rtl/instr_buffer_pkg.sv
// Shared widths, control levels and buffer defaults for the fetch/decode instruction buffer.
package instr_buffer_pkg;

  localparam int unsigned InstAddrBus    = 32;
  localparam int unsigned InstBus        = 32;
  localparam logic        Flush          = 1'b1;
  localparam logic        RstEnable      = 1'b1;
  localparam int unsigned IbufDepth      = 16;
  localparam int unsigned IbufFullMargin = 4;

  typedef struct packed {
    logic [InstAddrBus-1:0] pc;
    logic [InstBus-1:0]     inst;
  } ibuf_entry_t;

  function automatic logic [1:0] popcount2(input logic [1:0] v);
    return {1'b0, v[0]} + {1'b0, v[1]};
  endfunction

endpackage

// File: rtl/instr_buffer.sv
// Two-in/two-out circular instruction buffer between icache and dual-issue decode.
module instr_buffer
  import instr_buffer_pkg::*;
#(
  parameter int unsigned DEPTH       = IbufDepth,
  parameter int unsigned FULL_MARGIN = IbufFullMargin
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic [1:0]             inst_valid_i,
  input  logic [InstBus-1:0]     inst0_i,
  input  logic [InstBus-1:0]     inst1_i,
  input  logic [InstAddrBus-1:0] pc0_i,
  input  logic [1:0]             issue_i,
  output logic [1:0]             out_valid_o,
  output logic [InstBus-1:0]     inst0_o,
  output logic [InstAddrBus-1:0] pc0_o,
  output logic [InstBus-1:0]     inst1_o,
  output logic [InstAddrBus-1:0] pc1_o,
  output logic                   ibuffer_full,
  output logic                   overflow_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned SW = AW + 2;
  localparam logic [SW-1:0] DepthS   = SW'(DEPTH);
  localparam logic [CW-1:0] FullMark = CW'(DEPTH - FULL_MARGIN);

  ibuf_entry_t mem_q [DEPTH];

  logic [AW-1:0] head_q, tail_q, head1, tail1;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic [1:0]    nw, accepted;
  logic [SW-1:0] space;
  logic          clear;

  assign clear = (rst == RstEnable) || (flush == Flush);
  assign nw    = popcount2(inst_valid_i);
  assign head1 = head_q + AW'(1);
  assign tail1 = tail_q + AW'(1);

  // Space is measured after this cycle's issue so a full buffer can still accept while draining.
  always_comb begin
    space      = DepthS - SW'(count_q) + SW'(issue_i);
    accepted   = nw;
    overflow_d = 1'b0;
    if (space < SW'(nw)) begin
      accepted   = space[1:0];
      overflow_d = 1'b1;
    end
    count_d = count_q + CW'(accepted) - CW'(issue_i);
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      head_q     <= head_q + AW'(issue_i);
      tail_q     <= tail_q + AW'(accepted);
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage is never cleared; occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (!clear) begin
      if (accepted != 2'd0) mem_q[tail_q] <= '{pc: pc0_i, inst: inst0_i};
      if (accepted == 2'd2) mem_q[tail1]  <= '{pc: pc0_i + 32'h4, inst: inst1_i};
    end
  end

  always_comb begin
    out_valid_o = 2'b00;
    if (count_q == CW'(1)) begin
      out_valid_o = 2'b01;
    end else if (count_q != '0) begin
      out_valid_o = 2'b11;
    end
    inst0_o = out_valid_o[0] ? mem_q[head_q].inst : '0;
    pc0_o   = out_valid_o[0] ? mem_q[head_q].pc   : '0;
    inst1_o = out_valid_o[1] ? mem_q[head1].inst  : '0;
    pc1_o   = out_valid_o[1] ? mem_q[head1].pc    : '0;
  end

  assign ibuffer_full = (count_q >= FullMark);
  assign overflow_o   = overflow_q;

endmodule

// File: tb/tb_instr_buffer.sv
// Table-driven bench for instr_buffer with a queue scoreboard of expected buffer contents.
module tb_instr_buffer;

  localparam int Depth = 16;
  localparam int FullAt = 12;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  typedef struct {
    logic       r;
    logic       f;
    logic [1:0] v;
    logic [1:0] iss;
    int         cnt;
    logic       ovf;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst, flush;
  logic [1:0]  inst_valid_i, issue_i;
  logic [31:0] inst0_i, inst1_i, pc0_i;
  logic [1:0]  out_valid_o;
  logic [31:0] inst0_o, pc0_o, inst1_o, pc1_o;
  logic        ibuffer_full, overflow_o;

  int   n_vec = 0;
  int   n_bad = 0;
  ent_t sb[$];
  vec_t tbl[$];
  logic [31:0] cur_pc = 32'hbfc00000;

  instr_buffer #(.DEPTH(Depth), .FULL_MARGIN(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .inst_valid_i (inst_valid_i),
    .inst0_i      (inst0_i),
    .inst1_i      (inst1_i),
    .pc0_i        (pc0_i),
    .issue_i      (issue_i),
    .out_valid_o  (out_valid_o),
    .inst0_o      (inst0_o),
    .pc0_o        (pc0_o),
    .inst1_o      (inst1_o),
    .pc1_o        (pc1_o),
    .ibuffer_full (ibuffer_full),
    .overflow_o   (overflow_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return pc ^ 32'h1357_9bdf;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic f, input logic [1:0] v,
                     input logic [1:0] iss, input int cnt, input logic ovf);
    vec_t t;
    t.r = r; t.f = f; t.v = v; t.iss = iss; t.cnt = cnt; t.ovf = ovf;
    tbl.push_back(t);
  endtask

  task automatic apply(input vec_t t, input int idx);
    int   space, nw, acc;
    ent_t e0, e1;
    logic [1:0] ev;
    @(negedge clk);
    rst          = t.r;
    flush        = t.f;
    inst_valid_i = t.v;
    issue_i      = t.iss;
    pc0_i        = cur_pc;
    inst0_i      = inst_of(cur_pc);
    inst1_i      = inst_of(cur_pc + 32'h4);
    if (t.r || t.f) begin
      sb.delete();
    end else begin
      for (int k = 0; k < int'(t.iss); k++) void'(sb.pop_front());
      space = Depth - sb.size();
      nw    = int'(t.v[0]) + int'(t.v[1]);
      acc   = (nw <= space) ? nw : space;
      if (acc >= 1) sb.push_back('{pc: cur_pc, inst: inst_of(cur_pc)});
      if (acc == 2) sb.push_back('{pc: cur_pc + 32'h4, inst: inst_of(cur_pc + 32'h4)});
      cur_pc = cur_pc + 32'(4 * acc);
    end
    @(posedge clk);
    #1;
    ev = (t.cnt == 0) ? 2'b00 : (t.cnt == 1) ? 2'b01 : 2'b11;
    e0 = (sb.size() >= 1) ? sb[0] : '0;
    e1 = (sb.size() >= 2) ? sb[1] : '0;
    chk("out_valid", idx, 32'(out_valid_o), 32'(ev));
    chk("ibuffer_full", idx, 32'(ibuffer_full), 32'(t.cnt >= FullAt));
    chk("overflow", idx, 32'(overflow_o), 32'(t.ovf));
    chk("pc0", idx, pc0_o, e0.pc);
    chk("inst0", idx, inst0_o, e0.inst);
    chk("pc1", idx, pc1_o, e1.pc);
    chk("inst1", idx, inst1_o, e1.inst);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; inst_valid_i = '0; issue_i = '0;
    inst0_i = '0; inst1_i = '0; pc0_i = '0;

    // reset with a write present, then basic pair write/issue
    add(1, 0, 2'b11, 0, 0, 0);
    add(1, 0, 2'b00, 0, 0, 0);
    add(0, 0, 2'b11, 0, 2, 0);
    add(0, 0, 2'b00, 2, 0, 0);
    // single then pair, issue one
    add(0, 0, 2'b01, 0, 1, 0);
    add(0, 0, 2'b11, 0, 3, 0);
    add(0, 0, 2'b00, 1, 2, 0);
    add(0, 0, 2'b00, 2, 0, 0);
    // fill towards the full threshold
    for (int i = 0; i < 6; i++) add(0, 0, 2'b11, 0, 2 * (i + 1), 0);
    add(0, 0, 2'b01, 0, 13, 0);
    add(0, 0, 2'b11, 0, 15, 0);
    add(0, 0, 2'b11, 0, 16, 1);
    add(0, 0, 2'b11, 2, 16, 0);
    add(0, 0, 2'b11, 0, 16, 1);
    add(0, 0, 2'b00, 2, 14, 0);
    // mixed traffic wrapping both pointers
    add(0, 0, 2'b11, 1, 15, 0);
    add(0, 0, 2'b01, 2, 14, 0);
    add(0, 0, 2'b11, 2, 14, 0);
    add(0, 0, 2'b00, 2, 12, 0);
    add(0, 0, 2'b00, 2, 10, 0);
    add(0, 0, 2'b11, 1, 11, 0);
    add(0, 0, 2'b01, 2, 10, 0);
    add(0, 0, 2'b11, 2, 10, 0);
    add(0, 0, 2'b00, 1, 9, 0);
    // multi-cycle flush with writes and issue present
    add(0, 1, 2'b11, 2, 0, 0);
    add(0, 1, 2'b11, 0, 0, 0);
    add(0, 0, 2'b11, 0, 2, 0);
    add(0, 0, 2'b00, 2, 0, 0);

    foreach (tbl[i]) apply(tbl[i], i);

    // back-to-back dropping edges each pulse, then reset wins over flush mid-stream
    for (int i = 0; i < 8; i++) apply('{r: 0, f: 0, v: 2'b11, iss: 0, cnt: 2 * (i + 1),
                                        ovf: 0}, 100 + i);
    apply('{r: 0, f: 0, v: 2'b11, iss: 0, cnt: 16, ovf: 1}, 110);
    apply('{r: 0, f: 0, v: 2'b01, iss: 0, cnt: 16, ovf: 1}, 111);
    apply('{r: 0, f: 0, v: 2'b00, iss: 0, cnt: 16, ovf: 0}, 112);
    apply('{r: 0, f: 0, v: 2'b11, iss: 0, cnt: 16, ovf: 1}, 113);
    apply('{r: 1, f: 1, v: 2'b11, iss: 2, cnt: 0, ovf: 0}, 114);
    apply('{r: 0, f: 0, v: 2'b01, iss: 0, cnt: 1, ovf: 0}, 115);
    apply('{r: 0, f: 0, v: 2'b00, iss: 1, cnt: 0, ovf: 0}, 116);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
